gate_bist: RTL and testbench
============================

# gate_bist

Synthesizable built-in self-test sequencer for the two-input, six-output logic-gate block (`test_top`). On `start` it walks all four input combinations of `a`/`b`, waits a programmable settle time, samples the 6-bit gate vector, and compares it against a golden model. It reports pass/fail, an error count, and which combinations and which gate bits failed. It is the hardware counterpart of the stimulus bench: it drives the gate block's inputs and consumes its outputs, so no simulator is needed.

## Interface
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1  : single clock; all logic on its rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `start`  in  1  : one-cycle request to begin a test run; sampled only in IDLE or DONE.
- `a`  out  1  : stimulus to gate block input a (registered).
- `b`  out  1  : stimulus to gate block input b (registered).
- `dut_out`  in  6  : gate block result vector.
- `busy`  out  1  : run in progress (SETTLE or CHECK).
- `done`  out  1  : run complete; held until next `start` or `rst`.
- `pass`  out  1  : `done` && `err_cnt == 0`.
- `err_cnt`  out  3  : number of failing combinations, 0..4.
- `fail_vec`  out  4  : bit i set if combination i failed (i = {a,b}).
- `mismatch_mask`  out  6  : OR over all vectors of (`dut_out` XOR expected).

## Operation
- Golden mapping: `out[0]`=AND, `[1]`=OR, `[2]`=XOR, `[3]`=NAND, `[4]`=NOR, `[5]`=XNOR.
- Combination order is idx 0..3, with `a = idx[1]` and `b = idx[0]` (00, 01, 10, 11).
- FSM states and transitions:
  - IDLE: on `start`, go to SETTLE; set idx=0 and `a`=`b`=0; clear `err_cnt`, `fail_vec` and `mismatch_mask`; load the settle counter.
  - SETTLE: count down SETTLE_CYCLES cycles, holding `a`/`b` stable, then go to CHECK.
  - CHECK: one cycle. Compare `dut_out` with the expected vector. On mismatch, increment `err_cnt`, set `fail_vec[idx]`, and OR the XOR difference into `mismatch_mask`. If idx==3 go to DONE; otherwise idx++, update `a`/`b`, and go to SETTLE.
  - DONE: `done`=1 and `pass` valid. `start` here restarts exactly as from IDLE, clearing results.
- `start` while `busy` is ignored.
- `a`/`b` change only on the edge leaving CHECK (or the edge accepting `start`). They never glitch mid-vector.
- `err_cnt` saturation is unnecessary: the maximum is 4, which fits in 3 bits.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, `mismatch_mask`=0, state=IDLE.
- Each vector occupies SETTLE_CYCLES+1 cycles. `done` rises 4·(SETTLE_CYCLES+1) cycles after the edge that samples `start` (8 cycles at the default).
- `busy` is high from the edge after `start` is sampled until the edge that enters DONE. It falls in the same cycle `done` rises.
- `dut_out` is sampled at the rising edge that ends the CHECK cycle. By then the stimulus has been stable for at least SETTLE_CYCLES+1 edges.
- Result outputs update on that same edge. Partial results are visible while `busy` is high; they are final only when `done` is high.
- `rst` mid-run: on the next edge, everything returns to reset values and state goes to IDLE; the run is not resumed.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- `gate_bist_pkg` holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - gate bit-index constants (GATE_AND..GATE_XNOR);
  - the N_COMBOS=4 constant;
  - a function `expected_gates(a, b)` returning the 6-bit golden vector.
- One sub-module, `gate_golden`: a combinational wrapper around `expected_gates`, also reused by benches as a reference model.
- Top contains the FSM, settle counter, idx register and result registers.

## Test plan
- Correct gate model as DUT, default parameter, `start` pulse → `done` after 8 cycles, `pass`=1, `err_cnt`=0, `fail_vec`=0000, `mismatch_mask`=000000.
- DUT with `out[2]` stuck at 0 → `err_cnt`=2, `fail_vec`=0110, `mismatch_mask`=000100, `pass`=0.
- DUT output fully inverted → `err_cnt`=4, `fail_vec`=1111, `mismatch_mask`=111111.
- SETTLE_CYCLES=3 → `a`/`b` step through 00, 01, 10, 11, each held 4 cycles; `done` rises 16 cycles after `start`.
- `start` re-pulsed while `busy` → ignored, run timing unchanged. `start` in DONE → results cleared and new run begins.
- `rst` asserted during the third vector → next cycle all outputs at reset values and state IDLE; a subsequent `start` completes a full run normally.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and the golden gate model for the gate-block self-test sequencer.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_XOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XNOR = 5;

  localparam int N_COMBOS = 4;

  function automatic logic [5:0] expected_gates(input logic a, input logic b);
    logic [5:0] g;
    g            = '0;
    g[GATE_AND]  = a & b;
    g[GATE_OR]   = a | b;
    g[GATE_XOR]  = a ^ b;
    g[GATE_NAND] = ~(a & b);
    g[GATE_NOR]  = ~(a | b);
    g[GATE_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_bist_golden.sv
// Combinational golden reference for the six-output gate block.
module gate_golden
  import gate_bist_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [5:0] gates_o
);

  assign gates_o = expected_gates(a_i, b_i);

endmodule

// File: rtl/gate_bist.sv
// BIST sequencer: walks all a/b combinations, samples the gate block after a
// settle delay and accumulates pass/fail results against the golden model.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [5:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic [5:0] mismatch_mask
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_IDX    = 2'(N_COMBOS - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [1:0] idx_q;
  logic       a_q, b_q;
  logic       busy_q, done_q, pass_q;
  logic [2:0] err_cnt_q;
  logic [3:0] fail_vec_q;
  logic [5:0] mismatch_mask_q;

  logic [5:0] expected;
  logic [5:0] diff_d;
  logic       miss_d;
  logic [2:0] err_cnt_d;
  logic [1:0] idx_d;

  // a/b always mirror idx, so the golden vector tracks the applied stimulus.
  gate_golden u_golden (
    .a_i     (a_q),
    .b_i     (b_q),
    .gates_o (expected)
  );

  always_comb begin
    diff_d    = dut_out ^ expected;
    miss_d    = |diff_d;
    err_cnt_d = err_cnt_q + {2'b00, miss_d};
    idx_d     = idx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      a_q             <= 1'b0;
      b_q             <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_cnt_q       <= '0;
      fail_vec_q      <= '0;
      mismatch_mask_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q         <= ST_SETTLE;
            cnt_q           <= SETTLE_LOAD;
            idx_q           <= '0;
            a_q             <= 1'b0;
            b_q             <= 1'b0;
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_cnt_q       <= '0;
            fail_vec_q      <= '0;
            mismatch_mask_q <= '0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == 4'd0) state_q <= ST_CHECK;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_CHECK: begin
          err_cnt_q       <= err_cnt_d;
          mismatch_mask_q <= mismatch_mask_q | diff_d;
          if (miss_d) fail_vec_q[idx_q] <= 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == 3'd0);
          end else begin
            state_q <= ST_SETTLE;
            cnt_q   <= SETTLE_LOAD;
            idx_q   <= idx_d;
            a_q     <= idx_d[1];
            b_q     <= idx_d[0];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a             = a_q;
  assign b             = b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign fail_vec      = fail_vec_q;
  assign mismatch_mask = mismatch_mask_q;

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: healthy, stuck-XOR and inverted gate blocks,
// settle timing, restart/busy behaviour and mid-run reset.
module tb_gate_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  int         mode = 0;

  logic       a, b, busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  logic [5:0] mismatch_mask, dut_out;

  logic       a3, b3, busy3, done3, pass3;
  logic [2:0] err_cnt3;
  logic [3:0] fail_vec3;
  logic [5:0] mismatch_mask3, dut_out3;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Behavioural gate block with injectable faults: 1 = XOR stuck at 0, 2 = inverted.
  function automatic logic [5:0] gate_model(input logic ia, input logic ib, input int m);
    logic [5:0] g;
    g = {~(ia ^ ib), ~(ia | ib), ~(ia & ib), ia ^ ib, ia | ib, ia & ib};
    if (m == 1) g[2] = 1'b0;
    if (m == 2) g = ~g;
    return g;
  endfunction

  assign dut_out  = gate_model(a, b, mode);
  assign dut_out3 = gate_model(a3, b3, mode);

  gate_bist u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_vec(fail_vec), .mismatch_mask(mismatch_mask)
  );

  gate_bist #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
    .fail_vec(fail_vec3), .mismatch_mask(mismatch_mask3)
  );

  // Leaves the caller 1 time unit after the edge that samples start.
  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 3) start3 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        cycles = n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({a, b, busy, done, pass, err_cnt, fail_vec, mismatch_mask} !== 18'd0) begin
      $display("FAIL reset_outputs: got %b required all zero",
               {a, b, busy, done, pass, err_cnt, fail_vec, mismatch_mask});
    end else n_pass++;
    n_total++;
    if ({a3, b3, busy3, done3, pass3, err_cnt3, fail_vec3, mismatch_mask3} !== 18'd0) begin
      $display("FAIL reset_outputs3: got %b required all zero",
               {a3, b3, busy3, done3, pass3, err_cnt3, fail_vec3, mismatch_mask3});
    end else n_pass++;
    @(negedge clk); rst = 1'b0;
    $display("txn reset: outputs checked");
  endtask

  task automatic test_good_run();
    int cyc;
    mode = 0;
    pulse(1);
    n_total++;
    if (busy !== 1'b1) $display("FAIL good_busy_rise: got %b required 1", busy);
    else n_pass++;
    wait_done(cyc);
    n_total++;
    if (cyc != 8) $display("FAIL good_latency: got %0d required 8", cyc);
    else n_pass++;
    n_total++;
    if ({busy, pass, err_cnt, fail_vec, mismatch_mask} !== {1'b0, 1'b1, 3'd0, 4'b0000, 6'b000000})
      $display("FAIL good_results: busy=%b pass=%b err=%0d fv=%b mm=%b required busy=0 pass=1 err=0 fv=0000 mm=000000",
               busy, pass, err_cnt, fail_vec, mismatch_mask);
    else n_pass++;
    $display("txn good_run: cycles=%0d pass=%b err=%0d", cyc, pass, err_cnt);
  endtask

  task automatic test_stuck_xor();
    int cyc;
    mode = 1;
    pulse(1);
    wait_done(cyc);
    n_total++;
    if (cyc != 8) $display("FAIL xor_latency: got %0d required 8", cyc);
    else n_pass++;
    n_total++;
    if ({pass, err_cnt, fail_vec, mismatch_mask} !== {1'b0, 3'd2, 4'b0110, 6'b000100})
      $display("FAIL xor_results: pass=%b err=%0d fv=%b mm=%b required pass=0 err=2 fv=0110 mm=000100",
               pass, err_cnt, fail_vec, mismatch_mask);
    else n_pass++;
    $display("txn stuck_xor: err=%0d fv=%b mm=%b", err_cnt, fail_vec, mismatch_mask);
  endtask

  task automatic test_inverted();
    int cyc;
    mode = 2;
    pulse(1);
    wait_done(cyc);
    n_total++;
    if ({pass, err_cnt, fail_vec, mismatch_mask} !== {1'b0, 3'd4, 4'b1111, 6'b111111})
      $display("FAIL inv_results: pass=%b err=%0d fv=%b mm=%b required pass=0 err=4 fv=1111 mm=111111",
               pass, err_cnt, fail_vec, mismatch_mask);
    else n_pass++;
    $display("txn inverted: cycles=%0d err=%0d fv=%b", cyc, err_cnt, fail_vec);
  endtask

  task automatic test_settle3();
    int bad;
    mode = 0;
    bad = 0;
    pulse(3);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      n_total++;
      if ({a3, b3} !== 2'(k / 4) || done3 !== 1'b0 || busy3 !== 1'b1) begin
        $display("FAIL settle3_cycle%0d: ab=%b done=%b busy=%b required ab=%b done=0 busy=1",
                 k, {a3, b3}, done3, busy3, 2'(k / 4));
        bad++;
      end else n_pass++;
    end
    @(posedge clk); #1;
    n_total++;
    if ({done3, busy3, pass3, a3, b3} !== 5'b10111)
      $display("FAIL settle3_done: done=%b busy=%b pass=%b ab=%b required done=1 busy=0 pass=1 ab=11",
               done3, busy3, pass3, {a3, b3});
    else n_pass++;
    $display("txn settle3: bad_cycles=%0d done=%b", bad, done3);
  endtask

  task automatic test_back_to_back();
    int cyc;
    // Previous run left err=4; restart from DONE must clear everything.
    mode = 0;
    pulse(1);
    n_total++;
    if ({done, pass, busy, err_cnt, fail_vec, mismatch_mask} !== {1'b0, 1'b0, 1'b1, 13'd0})
      $display("FAIL restart_clear: done=%b pass=%b busy=%b err=%0d fv=%b mm=%b required done=0 pass=0 busy=1 rest 0",
               done, pass, busy, err_cnt, fail_vec, mismatch_mask);
    else n_pass++;
    cyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = (n == 3);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        cyc = n;
        break;
      end
    end
    n_total++;
    if (cyc != 8) $display("FAIL busy_start_ignored: done after %0d required 8", cyc);
    else n_pass++;
    n_total++;
    if (pass !== 1'b1) $display("FAIL restart_pass: got %b required 1", pass);
    else n_pass++;
    $display("txn back_to_back: cycles=%0d pass=%b", cyc, pass);
  endtask

  task automatic test_rst_mid();
    int cyc;
    mode = 2;
    pulse(1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_total++;
    if ({a, b, err_cnt} !== {2'b10, 3'd2})
      $display("FAIL rst_third_vector: ab=%b err=%0d required ab=10 err=2", {a, b}, err_cnt);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({a, b, busy, done, pass, err_cnt, fail_vec, mismatch_mask} !== 18'd0)
      $display("FAIL rst_mid_outputs: got %b required all zero",
               {a, b, busy, done, pass, err_cnt, fail_vec, mismatch_mask});
    else n_pass++;
    // rst and start together: reset wins.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++;
    if ({busy, done} !== 2'b00) $display("FAIL rst_beats_start: busy=%b done=%b required 00", busy, done);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_no_resume: busy=%b required 0", busy);
    else n_pass++;
    mode = 0;
    pulse(1);
    wait_done(cyc);
    n_total++;
    if (cyc != 8 || pass !== 1'b1 || err_cnt !== 3'd0)
      $display("FAIL rst_rerun: cycles=%0d pass=%b err=%0d required 8 1 0", cyc, pass, err_cnt);
    else n_pass++;
    $display("txn rst_mid: rerun cycles=%0d pass=%b", cyc, pass);
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_stuck_xor();
    test_inverted();
    test_settle3();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
